// File: rtl/tower_pkg.sv
// rtl/tower_pkg.sv - shared state type and size defaults for the sprite render scheduler
// Contents: state_e FSM encoding, default screen/sprite geometry, colour width.
// Optional feature macro: RENDER_CLEAR_EN (adds the ST_CLEAR full-screen wipe state).
package tower_pkg;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;
    localparam int SPR_W_DEF    = 4;
    localparam int SPR_H_DEF    = 4;
    localparam int COLOUR_W     = 3;

`ifdef RENDER_CLEAR_EN
    typedef enum logic [2:0] {ST_CLEAR, ST_IDLE, ST_ERASE, ST_DRAW, ST_DONE} state_e;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_ERASE, ST_DRAW, ST_DONE} state_e;
`endif

endpackage

// File: rtl/render_sched_rect_scan.sv
// rtl/render_sched_rect_scan.sv - row-major pixel scanner over an origin/size rectangle
// Ports: clk_i/rst_i clock and sync active-high reset; start_i restarts the scan at offset (0,0);
//        step_i advances one pixel (x offset fastest, wraps to (0,0) after the last pixel);
//        org_x_i/org_y_i rectangle origin; size_w_i/size_h_i rectangle size;
//        px_o/py_o current pixel, one bit wider than the screen coordinate so a wrapped
//        add stays visible to the caller; last_o high on the final pixel of the rectangle.
module rect_scan (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       step_i,
    input  logic [7:0] org_x_i,
    input  logic [6:0] org_y_i,
    input  logic [7:0] size_w_i,
    input  logic [6:0] size_h_i,
    output logic [8:0] px_o,
    output logic [7:0] py_o,
    output logic       last_o
);

    logic [7:0] cx_q, cx_d;
    logic [6:0] cy_q, cy_d;
    logic       end_x;

    assign end_x  = (cx_q == size_w_i - 8'd1);
    assign last_o = end_x && (cy_q == size_h_i - 7'd1);
    assign px_o   = {1'b0, org_x_i} + {1'b0, cx_q};
    assign py_o   = {1'b0, org_y_i} + {1'b0, cy_q};

    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (start_i) begin
            cx_d = '0;
            cy_d = '0;
        end else if (step_i) begin
            if (end_x) begin
                cx_d = '0;
                cy_d = last_o ? 7'd0 : cy_q + 7'd1;
            end else begin
                cx_d = cx_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

endmodule

// File: rtl/render_sched.sv
// rtl/render_sched.sv - sprite erase/redraw scheduler with wall-pixel arbitration onto one video write port
// Ports: CLOCK_50 clock; reset sync active-high; frame_tick starts a redraw;
//        dude_x/dude_y/dude_colour new sprite; bg_colour erase/clear colour;
//        wall_req/wall_x/wall_y/wall_colour wall pixel request, wall_ack combinational grant;
//        x/y/colour/plot registered video write port; busy high outside IDLE;
//        frame_done one-cycle pulse after each redraw.
// Optional feature macro: RENDER_CLEAR_EN (wipe the whole screen to bg_colour after reset).
module render_sched
    import tower_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int SPR_W    = SPR_W_DEF,
    parameter int SPR_H    = SPR_H_DEF
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                frame_tick,
    input  logic [7:0]          dude_x,
    input  logic [6:0]          dude_y,
    input  logic [COLOUR_W-1:0] dude_colour,
    input  logic [COLOUR_W-1:0] bg_colour,
    input  logic                wall_req,
    input  logic [7:0]          wall_x,
    input  logic [6:0]          wall_y,
    input  logic [COLOUR_W-1:0] wall_colour,
    output logic                wall_ack,
    output logic [7:0]          x,
    output logic [6:0]          y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                frame_done
);

`ifdef RENDER_CLEAR_EN
    localparam state_e RESET_STATE = ST_CLEAR;
`else
    localparam state_e RESET_STATE = ST_IDLE;
`endif

    state_e              state_q, state_d;
    logic                pending_q, pending_d;
    logic                prev_valid_q, prev_valid_d;
    logic [7:0]          prev_x_q, prev_x_d, cur_x_q, cur_x_d, x_q, x_d;
    logic [6:0]          prev_y_q, prev_y_d, cur_y_q, cur_y_d, y_q, y_d;
    logic [COLOUR_W-1:0] cur_c_q, cur_c_d, colour_q, colour_d;
    logic                plot_q, plot_d, frame_done_q, frame_done_d;

    logic                go, emit, scan_start, scan_step, scan_last;
    logic [7:0]          org_x, size_w;
    logic [6:0]          org_y, size_h;
    logic [8:0]          scan_px, emit_px;
    logic [7:0]          scan_py, emit_py;
    logic [COLOUR_W-1:0] emit_c;

    assign go         = frame_tick | pending_q;
    assign busy       = (state_q != ST_IDLE);
    assign x          = x_q;
    assign y          = y_q;
    assign colour     = colour_q;
    assign plot       = plot_q;
    assign frame_done = frame_done_q;

    // Scan rectangle selection lives apart from the main next-state block so the
    // scanner's pixel output never feeds back into the block that picks its origin.
    // In IDLE the origin is pre-selected so the first pixel leaves on the start edge.
    always_comb begin
        org_x  = cur_x_q;
        org_y  = cur_y_q;
        size_w = 8'(SPR_W);
        size_h = 7'(SPR_H);
        case (state_q)
`ifdef RENDER_CLEAR_EN
            ST_CLEAR: begin
                org_x  = '0;
                org_y  = '0;
                size_w = 8'(SCREEN_W);
                size_h = 7'(SCREEN_H);
            end
`endif
            ST_IDLE: begin
                org_x = prev_valid_q ? prev_x_q : dude_x;
                org_y = prev_valid_q ? prev_y_q : dude_y;
            end
            ST_ERASE: begin
                org_x = prev_x_q;
                org_y = prev_y_q;
            end
            default: ;
        endcase
    end

    rect_scan u_scan (
        .clk_i    (CLOCK_50),
        .rst_i    (reset),
        .start_i  (scan_start),
        .step_i   (scan_step),
        .org_x_i  (org_x),
        .org_y_i  (org_y),
        .size_w_i (size_w),
        .size_h_i (size_h),
        .px_o     (scan_px),
        .py_o     (scan_py),
        .last_o   (scan_last)
    );

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        prev_valid_d = prev_valid_q;
        prev_x_d     = prev_x_q;
        prev_y_d     = prev_y_q;
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        cur_c_d      = cur_c_q;
        frame_done_d = 1'b0;
        wall_ack     = 1'b0;
        scan_start   = 1'b0;
        scan_step    = 1'b0;
        emit         = 1'b0;
        emit_px      = scan_px;
        emit_py      = scan_py;
        emit_c       = cur_c_q;

        // A tick while busy is remembered once; later ones collapse into it.
        if (state_q != ST_IDLE && frame_tick) begin
            pending_d = 1'b1;
        end

        case (state_q)
`ifdef RENDER_CLEAR_EN
            ST_CLEAR: begin
                emit      = 1'b1;
                emit_c    = bg_colour;
                scan_step = 1'b1;
                if (scan_last) state_d = ST_IDLE;
            end
`endif
            ST_IDLE: begin
                if (go) begin
                    pending_d = 1'b0;
                    cur_x_d   = dude_x;
                    cur_y_d   = dude_y;
                    cur_c_d   = dude_colour;
                    emit      = 1'b1;
                    scan_step = 1'b1;
                    emit_c    = prev_valid_q ? bg_colour : dude_colour;
                    state_d   = prev_valid_q ? ST_ERASE : ST_DRAW;
                end else begin
                    scan_start = 1'b1;
                    if (wall_req) begin
                        wall_ack = 1'b1;
                        emit     = 1'b1;
                        emit_px  = {1'b0, wall_x};
                        emit_py  = {1'b0, wall_y};
                        emit_c   = wall_colour;
                    end
                end
            end
            ST_ERASE: begin
                emit      = 1'b1;
                emit_c    = bg_colour;
                scan_step = 1'b1;
                if (scan_last) state_d = ST_DRAW;
            end
            ST_DRAW: begin
                emit      = 1'b1;
                scan_step = 1'b1;
                if (scan_last) state_d = ST_DONE;
            end
            ST_DONE: begin
                frame_done_d = 1'b1;
                prev_x_d     = cur_x_q;
                prev_y_d     = cur_y_q;
                prev_valid_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // The wide sums catch both off-screen coordinates and 8-bit column wrap.
        plot_d   = emit && (emit_px < 9'(SCREEN_W)) && (emit_py < 8'(SCREEN_H));
        x_d      = plot_d ? emit_px[7:0] : x_q;
        y_d      = plot_d ? emit_py[6:0] : y_q;
        colour_d = plot_d ? emit_c : colour_q;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= RESET_STATE;
            pending_q    <= 1'b0;
            prev_valid_q <= 1'b0;
            prev_x_q     <= '0;
            prev_y_q     <= '0;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            cur_c_q      <= '0;
            plot_q       <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            prev_valid_q <= prev_valid_d;
            prev_x_q     <= prev_x_d;
            prev_y_q     <= prev_y_d;
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            cur_c_q      <= cur_c_d;
            plot_q       <= plot_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule
